// File: rtl/lm07_reader_if.sv
// Bus between the LM07 reader and its host/sensor side: request, serial pins, result word and status.
// fsm_state carries the reader's FSM encoding for observation.
interface lm07_reader_if #(
    parameter int NBITS = 16
);
    logic             start;
    logic             sio;
    logic             cs;
    logic             sclk;
    logic [NBITS-1:0] data_out;
    logic [12:0]      temp;
    logic             valid;
    logic             busy;
    logic [1:0]       fsm_state;

    // valid is a single-cycle strobe with no ready: the host must take data_out
    // in that cycle or read the held data_out later. start is honoured only while busy is low.
    modport master (
        output start, sio,
        input  cs, sclk, data_out, temp, valid, busy, fsm_state
    );

    modport slave (
        input  start, sio,
        output cs, sclk, data_out, temp, valid, busy, fsm_state
    );
endinterface

// File: rtl/lm07_reader.sv
// LM07 serial temperature sensor reader: drops cs, clocks NBITS bits in MSB first, then publishes the word.
// Optional macro LM07_AUTO_POLL_EN adds a free-running poll that relaunches a read POLL_GAP idle cycles after each one.
module lm07_reader #(
    parameter int CLK_DIV  = 4,
    parameter int NBITS    = 16,
    parameter int POLL_GAP = 100
) (
    input logic         clk,
    input logic         reset,
    lm07_reader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BW = $clog2(NBITS + 1);

    state_t           state, state_n;
    logic [7:0]       hcnt, hcnt_n;
    logic [BW-1:0]    bcnt, bcnt_n;
    logic             sclk_q, sclk_n;
    logic [NBITS-1:0] shreg, shreg_n;
    logic [NBITS-1:0] data_q, data_n;
    logic             launch;
    logic             last_half;

    assign last_half = (hcnt == 8'(CLK_DIV - 1));

`ifdef LM07_AUTO_POLL_EN
    localparam int GW = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);

    logic [GW-1:0] gap, gap_n;

    // Launching on the cycle the counter reads 1 makes the idle run exactly POLL_GAP cycles.
    assign launch = bus.start || (gap <= GW'(1));

    always_comb begin
        gap_n = gap;
        if (state == IDLE) begin
            if (launch) gap_n = GW'(POLL_GAP);
            else        gap_n = gap - GW'(1);
        end else if (state == DONE) begin
            gap_n = GW'(POLL_GAP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) gap <= GW'(POLL_GAP);
        else        gap <= gap_n;
    end
`else
    localparam int unused_poll_gap = POLL_GAP;

    assign launch = bus.start;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            hcnt   <= '0;
            bcnt   <= '0;
            sclk_q <= 1'b0;
            shreg  <= '0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            hcnt   <= hcnt_n;
            bcnt   <= bcnt_n;
            sclk_q <= sclk_n;
            shreg  <= shreg_n;
            data_q <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        bcnt_n  = bcnt;
        sclk_n  = sclk_q;
        shreg_n = shreg;
        data_n  = data_q;
        unique case (state)
            IDLE: begin
                hcnt_n = '0;
                bcnt_n = '0;
                sclk_n = 1'b0;
                if (launch) begin
                    shreg_n = '0;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (last_half) begin
                    hcnt_n  = '0;
                    state_n = SHIFT;
                end else begin
                    hcnt_n = hcnt + 8'd1;
                end
            end
            SHIFT: begin
                if (last_half) begin
                    hcnt_n = '0;
                    sclk_n = ~sclk_q;
                    // End of a low phase: the sensor bit is captured as sclk rises.
                    if (!sclk_q) begin
                        shreg_n = {shreg[NBITS-2:0], bus.sio};
                        bcnt_n  = bcnt + BW'(1);
                    end else if (bcnt == BW'(NBITS)) begin
                        data_n  = shreg;
                        state_n = DONE;
                    end
                end else begin
                    hcnt_n = hcnt + 8'd1;
                end
            end
            DONE: begin
                sclk_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // The temperature field sits in the top 13 bits of the 16-bit LM07 frame.
    assign bus.cs        = !((state == SETUP) || (state == SHIFT));
    assign bus.sclk      = sclk_q;
    assign bus.valid     = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.data_out  = data_q;
    assign bus.temp      = data_q[15:3];
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_lm07_reader.sv
// Self-checking bench for lm07_reader: table vectors, randomized reads against a frame model, and
// hand-written sequences for retrigger, held start, mid-transaction reset and (with the macro) auto-poll.
module tb_lm07_reader;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  lm07_reader_if #(.NBITS(16)) bm ();
  lm07_reader_if #(.NBITS(16)) b1 ();

  lm07_reader #(.CLK_DIV(4), .NBITS(16), .POLL_GAP(50000)) dut_m (.clk(clk), .reset(rst_n), .bus(bm));
  lm07_reader #(.CLK_DIV(1), .NBITS(16), .POLL_GAP(50000)) dut_1 (.clk(clk), .reset(rst_n), .bus(b1));

  // Sensor model: presents the MSB once cs drops, moves to the next bit after each sclk rise.
  logic [15:0] word_m = 16'h0;
  logic [15:0] word_1 = 16'h0;
  int rc_m = 0;
  int rc_1 = 0;

  always @(posedge bm.sclk or posedge bm.cs) if (bm.cs) rc_m <= 0; else rc_m <= rc_m + 1;
  always @(posedge b1.sclk or posedge b1.cs) if (b1.cs) rc_1 <= 0; else rc_1 <= rc_1 + 1;
  assign bm.sio = (rc_m < 16) ? word_m[4'(15 - rc_m)] : 1'b0;
  assign b1.sio = (rc_1 < 16) ? word_1[4'(15 - rc_1)] : 1'b0;

`ifdef LM07_AUTO_POLL_EN
  logic rst_a;
  logic [15:0] word_a = 16'h1234;
  int rc_a = 0;
  lm07_reader_if #(.NBITS(16)) ba ();
  lm07_reader #(.CLK_DIV(4), .NBITS(16), .POLL_GAP(10)) dut_a (.clk(clk), .reset(rst_a), .bus(ba));
  always @(posedge ba.sclk or posedge ba.cs) if (ba.cs) rc_a <= 0; else rc_a <= rc_a + 1;
  assign ba.sio = (rc_a < 16) ? word_a[4'(15 - rc_a)] : 1'b0;
`endif

  // Last word each instance should be holding (cleared by reset).
  logic [15:0] prev_m = 16'h0;
  logic [15:0] prev_1 = 16'h0;

  typedef struct {
    logic [15:0] word;
    int          div;
    int          retrig;
    logic [15:0] exp_data;
    logic [12:0] exp_temp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int div, input logic v);
    if (div == 1) b1.start = v;
    else          bm.start = v;
  endtask

  task automatic sample(input int div, output logic cs, output logic sclk, output logic valid,
                        output logic busy, output logic [15:0] d, output logic [12:0] t);
    if (div == 1) begin
      cs = b1.cs; sclk = b1.sclk; valid = b1.valid; busy = b1.busy; d = b1.data_out; t = b1.temp;
    end else begin
      cs = bm.cs; sclk = bm.sclk; valid = bm.valid; busy = bm.busy; d = bm.data_out; t = bm.temp;
    end
  endtask

  // One read: start in cycle 0, expected valid at cycle 33*div+1, observe three cycles beyond.
  task automatic run_txn(input logic [15:0] word, input int div, input int retrig,
                         input logic [15:0] exp_data, input logic [12:0] exp_temp);
    int L, k, lat, nvalid, cslow, rises, busy_bad, sclk_bad, hold_bad;
    logic cs, sclk, valid, busy, prev_sclk;
    logic [15:0] d, prevd;
    logic [12:0] t;
    L = 33 * div + 1;
    if (div == 1) begin word_1 = word; prevd = prev_1; end
    else          begin word_m = word; prevd = prev_m; end
    k = 0; lat = -1; nvalid = 0; cslow = 0; rises = 0;
    busy_bad = 0; sclk_bad = 0; hold_bad = 0; prev_sclk = 1'b0;
    d = '0; t = '0;
    @(negedge clk);
    set_start(div, 1'b1);
    while (k < L + 3) begin
      @(posedge clk);
      #1;
      k++;
      set_start(div, k == retrig);
      sample(div, cs, sclk, valid, busy, d, t);
      if (!cs) cslow++;
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (cs && sclk) sclk_bad++;
      if (busy !== (k <= L)) busy_bad++;
      if (valid) begin
        nvalid++;
        if (lat < 0) lat = k;
      end
      if (k < L && d !== prevd) hold_bad++;
    end
    chk("latency", 32'(lat), 32'(L));
    chk("valid_count", 32'(nvalid), 32'd1);
    chk("cs_low_cycles", 32'(cslow), 32'(L - 1));
    chk("sclk_rises", 32'(rises), 32'd16);
    chk("busy_profile", 32'(busy_bad), 32'd0);
    chk("sclk_while_cs_high", 32'(sclk_bad), 32'd0);
    chk("data_hold", 32'(hold_bad), 32'd0);
    chk("data_out", 32'(d), 32'(exp_data));
    chk("temp", 32'(t), 32'(exp_temp));
    if (div == 1) prev_1 = exp_data;
    else          prev_m = exp_data;
  endtask

  vec_t vecs[7];
  logic [31:0] exp_q[$];

  initial begin
    vecs[0] = '{16'h0C80, 4, -1, 16'h0C80, 13'h0190};
    vecs[1] = '{16'hFF18, 4, -1, 16'hFF18, 13'h1FE3};
    vecs[2] = '{16'hFFFF, 4, 40, 16'hFFFF, 13'h1FFF};
    vecs[3] = '{16'h0000, 4, -1, 16'h0000, 13'h0000};
    vecs[4] = '{16'hA5C3, 1, -1, 16'hA5C3, 13'h14B8};
    vecs[5] = '{16'h8001, 1, -1, 16'h8001, 13'h1000};
    vecs[6] = '{16'h0C80, 1, -1, 16'h0C80, 13'h0190};

    rst_n = 1'b0;
    bm.start = 1'b0;
    b1.start = 1'b0;
`ifdef LM07_AUTO_POLL_EN
    rst_a = 1'b0;
    ba.start = 1'b0;
`endif
    #1;
    chk("rst_cs", 32'(bm.cs), 32'd1);
    chk("rst_sclk", 32'(bm.sclk), 32'd0);
    chk("rst_valid", 32'(bm.valid), 32'd0);
    chk("rst_busy", 32'(bm.busy), 32'd0);
    chk("rst_data", 32'(bm.data_out), 32'd0);
    chk("rst_temp", 32'(bm.temp), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    begin
      int spur = 0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (bm.busy || b1.busy) spur++;
      end
      chk("no_start_no_txn", 32'(spur), 32'd0);
    end

    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].word, vecs[i].div, vecs[i].retrig, vecs[i].exp_data, vecs[i].exp_temp);

    for (int i = 0; i < 8; i++) begin
      logic [15:0] w;
      int dv;
      w  = 16'($urandom_range(0, 65535));
      dv = ($urandom_range(0, 1) == 1) ? 1 : 4;
      run_txn(w, dv, -1, w, 13'(w / 16'd8));
    end

    // start held high: the second read launches from the IDLE cycle right after DONE.
    begin
      int k, got;
      word_m = 16'h3C3C;
      exp_q.push_back(32'd133);
      exp_q.push_back(32'd267);
      got = 0;
      @(negedge clk);
      bm.start = 1'b1;
      for (k = 1; k <= 275; k++) begin
        @(posedge clk);
        #1;
        if (k == 200) bm.start = 1'b0;
        if (bm.valid) begin
          got++;
          if (exp_q.size() > 0) chk("held_start_valid_cycle", 32'(k), exp_q.pop_front());
          else                  chk("held_start_extra_valid", 32'(k), 32'd0);
          chk("held_start_data", 32'(bm.data_out), 32'h3C3C);
        end
      end
      chk("held_start_valid_total", 32'(got), 32'd2);
      exp_q.delete();
      prev_m = 16'h3C3C;
    end

    // Reset in cycle 60 of a read: outputs clear immediately and no valid follows.
    begin
      int k, vseen;
      word_m = 16'hBEEF;
      vseen = 0;
      @(negedge clk);
      bm.start = 1'b1;
      for (k = 1; k <= 60; k++) begin
        @(posedge clk);
        #1;
        bm.start = 1'b0;
        if (bm.valid) vseen++;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_cs", 32'(bm.cs), 32'd1);
      chk("midrst_sclk", 32'(bm.sclk), 32'd0);
      chk("midrst_data", 32'(bm.data_out), 32'd0);
      chk("midrst_busy", 32'(bm.busy), 32'd0);
      repeat (3) begin
        @(posedge clk);
        #1;
        if (bm.valid) vseen++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (150) begin
        @(posedge clk);
        #1;
        if (bm.valid) vseen++;
      end
      chk("midrst_no_valid", 32'(vseen), 32'd0);
      chk("midrst_data_held0", 32'(bm.data_out), 32'd0);
      prev_m = 16'h0;
      prev_1 = 16'h0;
      run_txn(16'h5A5A, 4, -1, 16'h5A5A, 13'h0B4B);
    end

`ifdef LM07_AUTO_POLL_EN
    // Auto-poll with start tied low: every idle run between reads is POLL_GAP cycles.
    begin
      int nval, idle_run, cyc;
      logic prev_busy;
      nval = 0; idle_run = 0; cyc = 0; prev_busy = 1'b0;
      @(negedge clk);
      rst_a = 1'b1;
      while (nval < 3 && cyc < 1000) begin
        @(posedge clk);
        #1;
        cyc++;
        if (ba.valid) begin
          nval++;
          chk("auto_data", 32'(ba.data_out), 32'h1234);
        end
        if (!ba.busy) idle_run++;
        if (ba.busy && !prev_busy) begin
          if (nval > 0) chk("auto_gap", 32'(idle_run), 32'd10);
          idle_run = 0;
        end
        prev_busy = ba.busy;
      end
      chk("auto_valid_count", 32'(nval), 32'd3);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
